// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 16-bit pipelined CPU: widths, opcode constants,
// instruction field positions and opcode-class helpers.
package cpu_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned NREG  = 8;
  localparam int unsigned IMM_W = 6;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;

  localparam logic [3:0] OP_ADDI   = 4'h8;
  localparam logic [3:0] OP_LD     = 4'h9;
  localparam logic [3:0] OP_ST     = 4'hA;
  localparam logic [3:0] OP_BR     = 4'hB;
  localparam logic [3:0] OP_FPU    = 4'hC;
  localparam logic [3:0] OP_CRYPTO = 4'hE;

  function automatic logic is_long(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return !op[3] || op == OP_ST || op == OP_BR || is_long(op);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return !(op == OP_ST || op == OP_BR);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-source operand resolution: EX (non-load) > MEM > WB > register file.
// With FWD_EN clear only the WB bypass remains.
module operand_bypass
  import cpu_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [AW-1:0] src,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [DW-1:0] rf_data,
  output logic [DW-1:0] data
);

  always_comb begin
    data = rf_data;
    if (FWD_EN && ex_wr_en && !ex_is_load && ex_rd == src)
      data = ex_result;
    else if (FWD_EN && mem_wr_en && mem_rd == src)
      data = mem_result;
    else if (wb_wr_en && wb_rd == src)
      data = wb_data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: forwarding, long-op scoreboard, hazard stall and ID/EX register.
// OF_FORWARD_EN enables EX/MEM forwarding; otherwise EX/MEM matches stall instead.
module operand_fetch_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_instr,
  output logic [AW-1:0] rf_rd_addr1,
  output logic [AW-1:0] rf_rd_addr2,
  input  logic [DW-1:0] rf_rd_data1,
  input  logic [DW-1:0] rf_rd_data2,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_wr_en,
  input  logic          wb_long,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_op,
  output logic [AW-1:0] out_rd,
  output logic          out_wr_en,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [DW-1:0] out_imm
);

`ifdef OF_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [3:0]      op;
  logic [AW-1:0]   rd, rs1, rs2;
  logic [DW-1:0]   a_data, b_data, imm;
  logic [NREG-1:0] sb, sb_next;
  logic            u2, load_use, sb_raw, sb_waw, ex_hit, mem_hit, hazard, load;

  assign op  = in_instr[OP_LSB +: 4];
  assign rd  = in_instr[RD_LSB +: AW];
  assign rs1 = in_instr[RS1_LSB +: AW];
  assign rs2 = in_instr[RS2_LSB +: AW];
  assign imm = {{(DW-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

  assign rf_rd_addr1 = rs1;
  assign rf_rd_addr2 = rs2;

  operand_bypass #(.FWD_EN(FWD_EN)) u_byp_a (
    .src(rs1), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .rf_data(rf_rd_data1), .data(a_data)
  );

  operand_bypass #(.FWD_EN(FWD_EN)) u_byp_b (
    .src(rs2), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .rf_data(rf_rd_data2), .data(b_data)
  );

  // Without forwarding, any in-flight EX/MEM producer of a used source must drain first.
  always_comb begin
    u2       = uses_rs2(op);
    load_use = ex_wr_en && ex_is_load && (ex_rd == rs1 || (u2 && ex_rd == rs2));
    sb_raw   = sb[rs1] || (u2 && sb[rs2]);
    sb_waw   = writes_rd(op) && sb[rd];
    ex_hit   = ex_wr_en && (ex_rd == rs1 || (u2 && ex_rd == rs2));
    mem_hit  = mem_wr_en && (mem_rd == rs1 || (u2 && mem_rd == rs2));
    hazard   = load_use || sb_raw || sb_waw || (!FWD_EN && (ex_hit || mem_hit));
  end

  assign in_ready = !hazard && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  // Issue of a long op is applied after the writeback clear so a same-register set wins.
  always_comb begin
    sb_next = sb;
    if (wb_wr_en && wb_long)
      sb_next[wb_rd] = 1'b0;
    if (out_valid && out_ready && is_long(out_op))
      sb_next[out_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb        <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_wr_en <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
    end else begin
      sb <= sb_next;
      if (load) begin
        out_valid <= 1'b1;
        out_op    <= op;
        out_rd    <= rd;
        out_wr_en <= writes_rd(op);
        out_a     <= a_data;
        out_b     <= b_data;
        out_imm   <= imm;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed scenarios then random traffic,
// checked against an ISA-level reference model; honours OF_FORWARD_EN.
module tb_operand_fetch_stage;

  typedef struct packed {
    logic        in_valid;
    logic [15:0] instr;
    logic        ex_wr_en;
    logic        ex_is_load;
    logic [2:0]  ex_rd;
    logic [15:0] ex_result;
    logic        mem_wr_en;
    logic [2:0]  mem_rd;
    logic [15:0] mem_result;
    logic        wb_wr_en;
    logic        wb_long;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_ready;
  } stim_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic        wr_en;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [2:0]  rf_rd_addr1, rf_rd_addr2;
  logic [15:0] rf_rd_data1, rf_rd_data2;
  logic        ex_wr_en = 1'b0, ex_is_load = 1'b0;
  logic [2:0]  ex_rd = '0;
  logic [15:0] ex_result = '0;
  logic        mem_wr_en = 1'b0;
  logic [2:0]  mem_rd = '0;
  logic [15:0] mem_result = '0;
  logic        wb_wr_en = 1'b0, wb_long = 1'b0;
  logic [2:0]  wb_rd = '0;
  logic [15:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_op;
  logic [2:0]  out_rd;
  logic        out_wr_en;
  logic [15:0] out_a, out_b, out_imm;

  logic [15:0] rf [8];
  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_long(wb_long), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_a(out_a), .out_b(out_b), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Reference model state: pending long-op destinations and the ID/EX occupant.
  bit [7:0]   m_sb = '0;
  bit         m_valid = 1'b0;
  logic [3:0] m_op = '0;
  logic [2:0] m_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_long(input logic [3:0] op);
    return op >= 4'd12;
  endfunction

  function automatic bit m_uses2(input logic [3:0] op);
    return op < 4'd8 || op == 4'd10 || op == 4'd11 || op >= 4'd12;
  endfunction

  function automatic bit m_writes(input logic [3:0] op);
    return op != 4'd10 && op != 4'd11;
  endfunction

  function automatic logic [15:0] m_resolve(input stim_t s, input logic [2:0] r);
`ifdef OF_FORWARD_EN
    if (s.ex_wr_en && !s.ex_is_load && s.ex_rd == r) return s.ex_result;
    if (s.mem_wr_en && s.mem_rd == r) return s.mem_result;
`endif
    if (s.wb_wr_en && s.wb_rd == r) return s.wb_data;
    return rf[r];
  endfunction

  function automatic bit m_hazard(input stim_t s);
    logic [3:0] op;
    logic [2:0] rd, r1, r2;
    bit u2;
    bit hz;
    op = s.instr[15:12]; rd = s.instr[11:9]; r1 = s.instr[8:6]; r2 = s.instr[5:3];
    u2 = m_uses2(op);
    hz = 1'b0;
    if (s.ex_wr_en && s.ex_is_load && (s.ex_rd == r1 || (u2 && s.ex_rd == r2))) hz = 1'b1;
    if (m_sb[r1] || (u2 && m_sb[r2])) hz = 1'b1;
    if (m_writes(op) && m_sb[rd]) hz = 1'b1;
`ifndef OF_FORWARD_EN
    if (s.ex_wr_en && (s.ex_rd == r1 || (u2 && s.ex_rd == r2))) hz = 1'b1;
    if (s.mem_wr_en && (s.mem_rd == r1 || (u2 && s.mem_rd == r2))) hz = 1'b1;
`endif
    return hz;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.out_ready = 1'b1;
    return s;
  endfunction

  function automatic logic [15:0] mk(input int op, input int rd, input int r1, input int r2);
    logic [15:0] w;
    w = {op[3:0], rd[2:0], r1[2:0], r2[2:0], 3'b000};
    return w;
  endfunction

  // Drives one cycle starting just after a rising edge, then advances past the next one.
  task automatic cycle(input stim_t s);
    bit   exp_ready, acc, consumed;
    exp_t e;
    int   iv;
    in_valid = s.in_valid; in_instr = s.instr;
    ex_wr_en = s.ex_wr_en; ex_is_load = s.ex_is_load; ex_rd = s.ex_rd; ex_result = s.ex_result;
    mem_wr_en = s.mem_wr_en; mem_rd = s.mem_rd; mem_result = s.mem_result;
    wb_wr_en = s.wb_wr_en; wb_long = s.wb_long; wb_rd = s.wb_rd; wb_data = s.wb_data;
    flush = s.flush; out_ready = s.out_ready;
    #1;
    exp_ready = !m_hazard(s) && (!m_valid || s.out_ready);
    check("in_ready", in_ready, exp_ready);
    check("rf_rd_addr2", rf_rd_addr2, s.instr[5:3]);
    acc = s.in_valid && exp_ready;
    consumed = m_valid && s.out_ready;
    if (acc) begin
      e.op = s.instr[15:12];
      e.rd = s.instr[11:9];
      e.wr_en = m_writes(e.op);
      e.a = m_resolve(s, s.instr[8:6]);
      e.b = m_resolve(s, s.instr[5:3]);
      iv = int'(s.instr[5:0]);
      if (iv >= 32) iv = iv - 64;
      e.imm = iv[15:0];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (s.wb_wr_en) rf[s.wb_rd] = s.wb_data;
    if (s.wb_wr_en && s.wb_long) m_sb[s.wb_rd] = 1'b0;
    if (consumed && m_long(m_op)) m_sb[m_rd] = 1'b1;
    if (acc) begin
      m_valid = 1'b1; m_op = s.instr[15:12]; m_rd = s.instr[11:9];
    end else if (s.flush) begin
      if (m_valid && !consumed) void'(q.pop_back());
      m_valid = 1'b0;
    end else if (consumed) begin
      m_valid = 1'b0;
    end
    check("out_valid", out_valid, m_valid);
  endtask

  // Monitor: every handshake on the execute side must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_issue: op=%0h with no expected entry at %0t", out_op, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_op", out_op, e.op);
        check("out_rd", out_rd, e.rd);
        check("out_wr_en", out_wr_en, e.wr_en);
        check("out_a", out_a, e.a);
        check("out_b", out_b, e.b);
        check("out_imm", out_imm, e.imm);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_imm", out_imm, 0);
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    rf[1] = 16'h0005; rf[2] = 16'h0007;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Plain ADD r3,r1,r2 from the register file.
    s = idle(); s.in_valid = 1; s.instr = mk(0, 3, 1, 2);
    cycle(s);
    cycle(idle());

    // EX and MEM both produce r1; EX must win (or stall without forwarding).
    s = idle(); s.in_valid = 1; s.instr = mk(0, 3, 1, 2);
    s.ex_wr_en = 1; s.ex_rd = 1; s.ex_result = 16'h1234;
    s.mem_wr_en = 1; s.mem_rd = 1; s.mem_result = 16'hAAAA;
    cycle(s);
    if (m_valid) s.in_valid = 0;
    s.ex_wr_en = 0; s.mem_wr_en = 0;
    cycle(s);
    cycle(idle());

    // Load-use: LD r2 in EX, then ADD r4,r2,r0 gets the loaded value from MEM.
    s = idle(); s.in_valid = 1; s.instr = mk(0, 4, 2, 0);
    s.ex_wr_en = 1; s.ex_is_load = 1; s.ex_rd = 2;
    cycle(s);
    s.ex_wr_en = 0; s.ex_is_load = 0; s.mem_wr_en = 1; s.mem_rd = 2; s.mem_result = 16'h5A5A;
    cycle(s);
    if (m_valid) s.in_valid = 0;
    s.mem_wr_en = 0;
    rf[2] = 16'h5A5A;
    cycle(s);
    cycle(idle());

    // FPU op to r5 sets the scoreboard; a dependent ADD waits for the long writeback.
    s = idle(); s.in_valid = 1; s.instr = mk(12, 5, 1, 2);
    cycle(s);
    cycle(idle());
    s = idle(); s.in_valid = 1; s.instr = mk(0, 6, 5, 1);
    cycle(s);
    cycle(s);
    s.wb_wr_en = 1; s.wb_long = 1; s.wb_rd = 5; s.wb_data = 16'h3C00;
    cycle(s);
    s.wb_wr_en = 0; s.wb_long = 0;
    cycle(s);
    cycle(idle());

    // Hold under backpressure, then flush the held entry away.
    s = idle(); s.in_valid = 1; s.instr = mk(8, 7, 3, 5) | 16'h0023;
    cycle(s);
    s = idle(); s.out_ready = 0; s.in_valid = 1; s.instr = mk(0, 1, 2, 3);
    repeat (3) cycle(s);
    s = idle(); s.out_ready = 0; s.flush = 1;
    cycle(s);

    // Asynchronous reset mid-stall with r5 pending.
    s = idle(); s.in_valid = 1; s.instr = mk(14, 5, 0, 0);
    cycle(s);
    cycle(idle());
    s = idle(); s.in_valid = 1; s.instr = mk(0, 6, 5, 1);
    cycle(s);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    m_sb = '0; m_valid = 1'b0; q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(s);
    cycle(idle());

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      s.in_valid   = ($urandom_range(0, 3) != 0);
      s.instr      = 16'($urandom);
      s.ex_wr_en   = ($urandom_range(0, 2) == 0);
      s.ex_is_load = 1'($urandom);
      s.ex_rd      = 3'($urandom);
      s.ex_result  = 16'($urandom);
      s.mem_wr_en  = ($urandom_range(0, 2) == 0);
      s.mem_rd     = 3'($urandom);
      s.mem_result = 16'($urandom);
      s.wb_wr_en   = 1'($urandom);
      s.wb_long    = 1'($urandom);
      s.wb_rd      = 3'($urandom);
      s.wb_data    = 16'($urandom);
      s.flush      = ($urandom_range(0, 9) == 0);
      s.out_ready  = ($urandom_range(0, 3) != 0);
      cycle(s);
    end

    s = idle();
    repeat (2) cycle(s);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode/operand-fetch stage of the 16-bit pipelined CPU, between instruction fetch and execute. It drives the register-file read addresses and resolves read data against in-flight results through a forwarding network. It tracks outstanding FPU/crypto writes in an 8-entry scoreboard, stalls on hazards, and registers the decoded operands into the ID/EX pipeline register with a valid/ready handshake.

## Interface
- No parameters. Data width 16, register address width 3 (8 registers), fixed by the ISA.
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid / in_ready  in / out  1  fetch handshake; in_ready combinational
- in_instr  in  16  op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm6 = [5:0]
- rf_rd_addr1 / rf_rd_addr2  out  3  = in_instr rs1 / rs2, combinational
- rf_rd_data1 / rf_rd_data2  in  16  combinational register-file read data
- ex_wr_en, ex_is_load, ex_rd[2:0], ex_result[15:0]  in  instruction currently in EX
- mem_wr_en, mem_rd[2:0], mem_result[15:0]  in  instruction currently in MEM
- wb_wr_en, wb_long, wb_rd[2:0], wb_data[15:0]  in  writeback port; mirrors register-file write inputs
- flush  in  1  kill the ID/EX register contents (branch redirect)
- out_valid / out_ready  out / in  1  execute handshake
- out_op[3:0], out_rd[2:0], out_wr_en, out_a[15:0], out_b[15:0], out_imm[15:0]  out  ID/EX register

## Operation
- Opcode classes:
  - 0x0–0x7: ALU reg-reg.
  - 0x8: ADDI.
  - 0x9: LD.
  - 0xA: ST.
  - 0xB: BR.
  - 0xC–0xD: FPU.
  - 0xE–0xF: CRYPTO.
- Long op: op[3:2] == 2'b11.
- uses_rs2: op < 8, ST, BR, or long op.
- writes_rd: every op except ST and BR.
- out_imm = sign-extended imm6.
- Operand resolution, per source, in priority order:
  1. EX (ex_wr_en && ex_rd match, not a load).
  2. MEM.
  3. WB.
  4. Register file.
- Register 0 is ordinary; it is not hardwired to zero.
- Scoreboard sb[7:0] has one pending bit per register:
  - Set sb[out_rd] on issue (out_valid && out_ready) of a long op.
  - Clear sb[wb_rd] when wb_wr_en && wb_long.
  - Set and clear of the same register in the same cycle: set wins.
- hazard is asserted by any of:
  - Load-use: ex_wr_en && ex_is_load && ex_rd matches rs1, or rs2 when uses_rs2.
  - Scoreboard RAW: sb[rs1], or sb[rs2] when uses_rs2.
  - Scoreboard WAW: sb[rd] when writes_rd.
- in_ready = !hazard && (!out_valid || out_ready).
- Load ID/EX on in_valid && in_ready. The new instruction takes precedence over flush in the same cycle.
- Consumed with no new load → out_valid falls (bubble).
- flush without a load → out_valid falls; the scoreboard is untouched.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is presented on the outputs from N to N+1.
- Back-to-back acceptance at full throughput when no hazard and out_ready is high.
- Load-use costs exactly 1 bubble.
- A scoreboard stall lasts until the cycle after the clearing writeback edge.
- Reset values:
  - out_valid = 0.
  - All out_* fields = 0.
  - sb = 0.
- Asserting rst mid-operation drops any held instruction. Upstream must replay it.
- out_* fields are held stable while out_valid && !out_ready.
- Hazard evaluation is combinational on the current EX/MEM/WB inputs.

## Configuration
- OF_FORWARD_EN defined: full EX/MEM/WB forwarding as described.
- Undefined:
  - EX and MEM forwarding removed.
  - Any EX/MEM write match on a used source is added to hazard.
  - WB bypass remains, because the register file does not return same-cycle write data.

## Structure
- Shared package cpu_pkg holds:
  - Opcode constants.
  - Field-slice localparams.
  - Functions is_long, uses_rs2, writes_rd.
- One sub-module: operand_bypass, the per-source priority forwarding mux. It is instantiated twice.

## Test plan
- Reset, then ADD r3,r1,r2 with rf r1=0x0005, r2=0x0007 → next cycle out_valid=1, out_a=0x0005, out_b=0x0007, out_rd=3.
- ex_wr_en with ex_rd=1, ex_result=0x1234, mem_rd=1, mem_result=0xAAAA → out_a=0x1234 (EX priority). Without OF_FORWARD_EN → in_ready=0 until the match clears.
- LD r2 in EX (ex_is_load=1), then ADD r4,r2,r0 arrives → in_ready=0 for 1 cycle, bubble (out_valid=0), then issue with the MEM-forwarded value.
- FPU op writing r5 issues; next ADD r6,r5,r1 → stalls. Assert wb_wr_en, wb_long, wb_rd=5, wb_data=0x3C00 → issues next cycle with out_a=0x3C00 and sb[5]=0.
- out_ready=0 for 3 cycles with a valid held → outputs unchanged and in_ready=0. Assert flush with no new input → out_valid=0.
- rst asserted mid-stall with sb=0x20 → out_valid=0 and sb=0 immediately, asynchronously.
